// File: rtl/ser_frame_pkg.sv
// Shared definitions for the serial frame receiver: receive-state encoding
// and the default frame geometry used by ser_frame_rx.
package ser_frame_pkg;

    // Default number of data bits carried by one frame.
    localparam int DATA_W_DEF       = 32'sd8;

    // Default number of clock cycles per serial bit (must be even, >= 2).
    localparam int CLKS_PER_BIT_DEF = 32'sd4;

    // Receive FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,  // line idle, waiting for a falling edge
        ST_START = 3'd1,  // half-bit wait to confirm the start bit
        ST_DATA  = 3'd2,  // sampling data bits at mid-bit
        ST_STOP  = 3'd3,  // sampling the stop bit
        ST_BREAK = 3'd4   // stop bit was low; wait for the line to return high
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit. Both flops
// reset to RST_VAL so the output shows a known level during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/ser_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, stop bit.
// The line is synchronized, the start bit confirmed at mid-bit, data and
// stop bits sampled at mid-bit. A good frame is handed to a one-entry
// valid/ready output register; a frame arriving while that register is
// still occupied is dropped and reported with an overrun pulse.
module ser_frame_rx
    import ser_frame_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun
);

    // Timer counts cycles within one bit; counter indexes the data bit.
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = $clog2(DATA_W + 32'sd1);

    localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
    localparam logic [TMR_W-1:0] FULL_LAST = TMR_W'(CLKS_PER_BIT - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 32'sd1);

    logic              line_s;
    rx_state_e         state_r;
    rx_state_e         state_nxt_s;
    logic [TMR_W-1:0]  timer_r;
    logic [TMR_W-1:0]  timer_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_nxt_s;
    logic              deliver_s;
    logic              ferr_s;
    logic              done_r;
    logic [1:0]        settle_r;
    logic              armed_r;
    logic [DATA_W-1:0] rx_data_r;
    logic              rx_valid_r;
    logic              frame_err_r;
    logic              overrun_r;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (line_s)
    );

    // Arm start detection only once the synchronizer carries real samples
    // and the line has been seen idle-high; a frame cut by reset is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= 2'b00;
            armed_r  <= 1'b0;
        end else begin
            settle_r <= {settle_r[0], 1'b1};
            if (settle_r[1] && line_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Receive FSM state, bit timer, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= TMR_ZERO;
            cnt_r   <= CNT_ZERO;
            shift_r <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
            done_r  <= deliver_s;
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit timer
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r + TMR_ONE;
        cnt_nxt_s   = cnt_r;
        shift_nxt_s = shift_r;
        deliver_s   = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                timer_nxt_s = TMR_ZERO;
                cnt_nxt_s   = CNT_ZERO;
                if (armed_r && !line_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == HALF_LAST) begin
                    timer_nxt_s = TMR_ZERO;
                    if (!line_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (timer_r == FULL_LAST) begin
                    timer_nxt_s = TMR_ZERO;
                    shift_nxt_s = {line_s, shift_r[DATA_W-1:1]};
                    if (cnt_r == BIT_LAST) begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_STOP;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (timer_r == FULL_LAST) begin
                    timer_nxt_s = TMR_ZERO;
                    if (line_s) begin
                        deliver_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ferr_s      = 1'b1;
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                timer_nxt_s = TMR_ZERO;
                if (line_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                timer_nxt_s = TMR_ZERO;
                cnt_nxt_s   = CNT_ZERO;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output register: accept handshakes, load delivered words, flag drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_r   <= {DATA_W{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            overrun_r   <= 1'b0;
            if (done_r) begin
                if (rx_valid_r && !rx_ready) begin
                    overrun_r <= 1'b1;
                end else begin
                    rx_data_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                end
            end else if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Directed self-checking bench for ser_frame_rx at default parameters.
module tb_ser_frame_rx;

    localparam int DW  = 8;
    localparam int CPB = 4;

    logic          clk;
    logic          rst_n;
    logic          rx_in;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;

    int cmp_cnt;
    int err_cnt;

    // event tallies gathered from the output pins
    logic [DW-1:0] acc_q[$];
    int ovr_cnt;
    int ovr_dbl;
    int ferr_cnt;
    int ferr_dbl;
    logic ovr_prev;
    logic ferr_prev;

    ser_frame_rx #(
        .DATA_W       (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record handshakes and pulse events as seen at each rising edge
    initial begin
        ovr_cnt   = 0;
        ovr_dbl   = 0;
        ferr_cnt  = 0;
        ferr_dbl  = 0;
        ovr_prev  = 1'b0;
        ferr_prev = 1'b0;
    end
    always @(posedge clk) begin
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (overrun && ovr_prev) ovr_dbl <= ovr_dbl + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (frame_err && ferr_prev) ferr_dbl <= ferr_dbl + 1;
        ovr_prev  <= overrun;
        ferr_prev <= frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame starting at a falling clock edge; returns one frame
    // time later, just before rising edge 40 counted from the start edge.
    task automatic send_frame(input logic [DW-1:0] w, input logic stop_bit);
        logic [DW+1:0] bits;
        bits = {stop_bit, w, 1'b0};
        @(negedge clk);
        for (int i = 0; i < DW + 2; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // After send_frame: rx_valid low at edge 40, high with the word at 41
    task automatic expect_delivery(input string tag, input logic [DW-1:0] w);
        @(posedge clk); #1;
        chk({tag, "_early"}, {31'd0, rx_valid}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, w});
    endtask

    initial begin
        int base_acc;
        int base_ovr;
        int base_ferr;
        logic seen;

        cmp_cnt  = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // 0xA5 with consumer ready: exact latency, single-cycle valid
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        expect_delivery("a5", 8'hA5);
        @(posedge clk); #1;
        chk("a5_drop", {31'd0, rx_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // 0x3C then 0xC3 with consumer stalled: second word overruns
        rx_ready = 1'b0;
        base_acc = acc_q.size();
        base_ovr = ovr_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("ovr_valid", {31'd0, rx_valid}, 32'd1);
        chk("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        chk("ovr_pulses", ovr_cnt - base_ovr, 32'd1);
        chk("ovr_width", ovr_dbl, 32'd0);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovr_accept_drop", {31'd0, rx_valid}, 32'd0);
        chk("ovr_accept_cnt", acc_q.size() - base_acc, 32'd1);
        chk("ovr_accept_word", {24'd0, acc_q[acc_q.size() - 1]}, 32'h3C);
        repeat (4) @(negedge clk);

        // 0x81 with low stop bit, line held low, then recovery with 0x42
        base_acc  = acc_q.size();
        base_ferr = ferr_cnt;
        send_frame(8'h81, 1'b0);
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("ferr_pulses", ferr_cnt - base_ferr, 32'd1);
        chk("ferr_width", ferr_dbl, 32'd0);
        chk("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("ferr_no_accept", acc_q.size() - base_acc, 32'd0);
        send_frame(8'h42, 1'b1);
        expect_delivery("after_break", 8'h42);
        repeat (4) @(negedge clk);

        // one-cycle glitch on the idle line is rejected silently
        base_ovr  = ovr_cnt;
        base_ferr = ferr_cnt;
        seen = 1'b0;
        @(negedge clk);
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rx_valid || frame_err || overrun) seen = 1'b1;
        end
        chk("glitch_quiet", {31'd0, seen}, 32'd0);
        chk("glitch_flags", (ovr_cnt - base_ovr) + (ferr_cnt - base_ferr), 32'd0);
        send_frame(8'h96, 1'b1);
        expect_delivery("after_glitch", 8'h96);
        repeat (4) @(negedge clk);

        // back-to-back 0x00, 0xFF, 0x55 with each accepted on delivery
        base_acc = acc_q.size();
        base_ovr = ovr_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        repeat (4) @(posedge clk); #1;
        chk("b2b_count", acc_q.size() - base_acc, 32'd3);
        if (acc_q.size() - base_acc == 3) begin
            chk("b2b_w0", {24'd0, acc_q[base_acc]}, 32'h00);
            chk("b2b_w1", {24'd0, acc_q[base_acc + 1]}, 32'hFF);
            chk("b2b_w2", {24'd0, acc_q[base_acc + 2]}, 32'h55);
        end
        chk("b2b_no_ovr", ovr_cnt - base_ovr, 32'd0);
        repeat (4) @(negedge clk);

        // reset mid-frame with a pending word, partial frame ignored
        rx_ready = 1'b0;
        send_frame(8'h7E, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, rx_valid}, 32'd1);
        @(negedge clk);
        rx_in = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
        chk("midrst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (rx_valid || frame_err) seen = 1'b1;
        end
        chk("postrst_quiet", {31'd0, seen}, 32'd0);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        expect_delivery("postrst", 8'h5A);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ser_frame_rx.md
SER_FRAME_RX -- requirements
Module: ser_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, number of data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; it SHALL be even and >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_in  input  1  asynchronous serial line; idle high, frame = start(0), DATA_W bits LSB first, stop(1).
REQ-006 rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-007 rx_data  output  DATA_W  received word.
REQ-008 rx_valid  output  1  rx_data holds an unaccepted word.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed frame dropped because the output was occupied.

Function
REQ-011 rx_in SHALL pass through a 2-FF synchronizer before any use; its flops SHALL reset to 1.
REQ-012 States SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-013 IDLE: a synchronized low SHALL move the block to START and clear the bit-timer.
REQ-014 START: after CLKS_PER_BIT/2 cycles the line SHALL be resampled; low -> DATA, high -> IDLE (glitch rejected, no flag).
REQ-015 DATA: the line SHALL be sampled every CLKS_PER_BIT cycles, DATA_W samples shifted in LSB first; after the last sample -> STOP.
REQ-016 STOP: one sample after CLKS_PER_BIT cycles; high -> frame delivered, go IDLE; low -> frame_err pulse, word discarded, go BREAK.
REQ-017 BREAK: the block SHALL remain until the synchronized line is high, then go IDLE.
REQ-018 Delivery SHALL load rx_data and assert rx_valid in the cycle after the stop sample.
REQ-019 From the first rising edge sampling rx_in low, rx_valid SHALL rise after exactly 3 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT cycles (41 at defaults).
REQ-020 rx_valid SHALL stay high and rx_data stable until a cycle with rx_valid && rx_ready; rx_valid SHALL drop the following cycle.
REQ-021 Delivery while rx_valid is high and rx_ready is low SHALL pulse overrun, keep the old rx_data, and drop the new word.
REQ-022 Delivery in the same cycle as an accepting handshake SHALL load the new word, keep rx_valid high, and not pulse overrun.
REQ-023 Back-to-back frames (stop bit directly followed by a start bit) SHALL be received without loss.
REQ-024 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, rx_valid=0, rx_data=0, frame_err=0, overrun=0, timer and bit count=0, and synchronizer=1, even mid-frame.
REQ-026 After rst_n is released, the partial frame SHALL be ignored; reception SHALL restart on the next high-to-low line transition seen from IDLE.

Structure
REQ-027 A shared package ser_frame_pkg SHALL hold the state enumeration and the default DATA_W and CLKS_PER_BIT constants.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff, with a reset value parameter.
REQ-029 Bit-timer and bit-counter widths SHALL be derived by $clog2 from the parameters; no fixed widths.

Verification
REQ-030 Reset sequence: rst_n low mid-frame -> all outputs 0 within the same cycle, and no rx_valid for that frame after release.
REQ-031 Frame 0xA5 at defaults with rx_ready=1 -> rx_valid one cycle exactly 41 cycles after the start edge, rx_data=0xA5.
REQ-032 Frames 0x3C then 0xC3 with rx_ready=0 -> rx_data stays 0x3C, one overrun pulse; after rx_ready=1, one accept and rx_valid drops.
REQ-033 Frame 0x81 with stop bit forced 0 -> one frame_err pulse, no rx_valid; line held low 20 cycles then high -> next 0x42 frame received correctly.
REQ-034 1-cycle low glitch on idle line -> no state leaves IDLE beyond START, no outputs change.
REQ-035 Back-to-back frames 0x00, 0xFF, 0x55 with rx_ready pulsed on each delivery cycle -> three words in order, no overrun.
